// File: rtl/mdu_iter_if.sv
// -----------------------------------------------------------------------------
// mdu_iter_if
// Execute-stage <-> iterative multiply/divide unit bus.
//
// Signals (WIDTH = operand width, must match the mdu_iter WIDTH):
//   start              launch request, sampled only while the unit is idle
//   op[2:0]            000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                      100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
//   opa, opb           multiplicand/dividend, multiplier/divisor
//   acc_hi_i, acc_lo_i forwarded HI/LO used as accumulator by MADD/MSUB
//   annul              flush the operation in flight
//   busy               operation in flight (stall request)
//   ready              one-cycle result-valid pulse
//   hi_o, lo_o         result: product high/low, or remainder/quotient
//
// Modports: master = execute stage, slave = mdu_iter.
// -----------------------------------------------------------------------------
interface mdu_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi_i;
  logic [WIDTH-1:0] acc_lo_i;
  logic             annul;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start, op, opa, opb, acc_hi_i, acc_lo_i, annul,
    input  busy, ready, hi_o, lo_o
  );

  modport slave (
    input  start, op, opa, opb, acc_hi_i, acc_lo_i, annul,
    output busy, ready, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative multiply/divide unit shared by MULT[U], DIV[U] and, when
// MDU_ACCUM_EN is defined, MADD[U]/MSUB[U]. One shift-add (multiply) or
// restoring subtract-shift (divide) step per cycle over WIDTH cycles on
// operand magnitudes, then one FIX cycle for sign correction / accumulate.
// Latency from the start edge to the ready pulse is WIDTH+1 edges; the unit
// is idle again WIDTH+2 edges after start.
//
// Build option: `MDU_ACCUM_EN
//   defined   - accumulate ops are built (acc registers + 2*WIDTH add/sub).
//   undefined - op[2] is ignored (MADD/MSUB run as MULT, the U forms as
//               MULTU); acc inputs unused.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   bus   mdu_iter_if.slave (start/op/operands/annul in, busy/ready/hi/lo out)
//
// Parameters:
//   WIDTH  operand width (default 32)
//   CNT_W  iteration counter width, 2**CNT_W > WIDTH (default 6)
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  mdu_iter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Operation context captured at launch.
  logic              div_q, div_d;
  logic              dz_q, dz_d;       // divide by zero
  logic              neg_a_q, neg_a_d; // signed op and opa negative
  logic              neg_b_q, neg_b_d; // signed op and opb negative
  logic [WIDTH-1:0]  a_mag_q, a_mag_d;
  logic [WIDTH-1:0]  b_mag_q, b_mag_d;

  // Working pair: multiply = {partial high, multiplier shifting out},
  // divide = {partial remainder, dividend shifting out / quotient in}.
  logic [WIDTH-1:0]  rw_hi_q, rw_hi_d;
  logic [WIDTH-1:0]  rw_lo_q, rw_lo_d;

`ifdef MDU_ACCUM_EN
  logic                acc_op_q, acc_op_d;
  logic                sub_q, sub_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
`endif

  // ---------------------------------------------------------------------------
  // Launch decode
  // ---------------------------------------------------------------------------
  logic             launch;
  logic             sgn_now;
  logic             div_now;
  logic             neg_a_now;
  logic             neg_b_now;
  logic [WIDTH-1:0] a_mag_now;
  logic [WIDTH-1:0] b_mag_now;

  assign launch    = (state_q == S_IDLE) && bus.start && !bus.annul;
  assign sgn_now   = ~bus.op[0];
  // 11x with op[2]=1 is MSUB (or MULT when accumulate is not built), never DIV.
  assign div_now   = bus.op[1] & ~bus.op[2];
  assign neg_a_now = sgn_now & bus.opa[WIDTH-1];
  assign neg_b_now = sgn_now & bus.opb[WIDTH-1];
  assign a_mag_now = neg_a_now ? -bus.opa : bus.opa;
  assign b_mag_now = neg_b_now ? -bus.opb : bus.opb;

  // ---------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_trial;

  assign mul_addend = rw_lo_q[0] ? a_mag_q : '0;
  assign mul_sum    = {1'b0, rw_hi_q} + {1'b0, mul_addend};
  // Trial subtract of the divisor from the remainder shifted left by one with
  // the next dividend bit; a clear MSB means the subtraction fits.
  assign div_trial  = {1'b0, rw_hi_q, rw_lo_q[WIDTH-1]} - {2'b00, b_mag_q};

  // ---------------------------------------------------------------------------
  // FIX-cycle result
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_sgn;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign prod_mag = {rw_hi_q, rw_lo_q};
  assign prod_sgn = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
`ifdef MDU_ACCUM_EN
  assign mul_res  = !acc_op_q ? prod_sgn
                  : sub_q     ? acc_q - prod_sgn
                  :             acc_q + prod_sgn;
`else
  assign mul_res  = prod_sgn;
`endif
  assign quot  = (neg_a_q ^ neg_b_q) ? -rw_lo_q : rw_lo_q;
  assign rem   = neg_a_q ? -rw_hi_q : rw_hi_q;
  // The raw dividend is recovered from its magnitude instead of being stored.
  assign raw_a = neg_a_q ? -a_mag_q : a_mag_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    res_hi = mul_res[2*WIDTH-1:WIDTH];
    res_lo = mul_res[WIDTH-1:0];
    if (dz_q) begin
      res_hi = raw_a;
      res_lo = '1;
    end else if (div_q) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          cnt_d = '0;
          // Divide by zero skips the iterations; FIX writes the fixed result.
          state_d = (div_now && (bus.opb == '0)) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (bus.annul) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX:   state_d = bus.annul ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d   = div_q;
    dz_d    = dz_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    rw_hi_d = rw_hi_q;
    rw_lo_d = rw_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_ACCUM_EN
    acc_op_d = acc_op_q;
    sub_d    = sub_q;
    acc_d    = acc_q;
`endif

    if (launch) begin
      div_d   = div_now;
      dz_d    = div_now && (bus.opb == '0);
      neg_a_d = neg_a_now;
      neg_b_d = neg_b_now;
      a_mag_d = a_mag_now;
      b_mag_d = b_mag_now;
      rw_hi_d = '0;
      rw_lo_d = div_now ? a_mag_now : b_mag_now;
`ifdef MDU_ACCUM_EN
      acc_op_d = bus.op[2];
      sub_d    = bus.op[1];
      acc_d    = {bus.acc_hi_i, bus.acc_lo_i};
`endif
    end

    if (state_q == S_CALC) begin
      if (div_q) begin
        if (!div_trial[WIDTH+1]) begin
          rw_hi_d = div_trial[WIDTH-1:0];
          rw_lo_d = {rw_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          rw_hi_d = {rw_hi_q[WIDTH-2:0], rw_lo_q[WIDTH-1]};
          rw_lo_d = {rw_lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        rw_hi_d = mul_sum[WIDTH:1];
        rw_lo_d = {mul_sum[0], rw_lo_q[WIDTH-1:1]};
      end
    end

    if ((state_q == S_FIX) && !bus.annul) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: operand/working registers carry no reset; each launch loads them
  // before anything reads them.
  always_ff @(posedge clk) begin
    div_q   <= div_d;
    dz_q    <= dz_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
    a_mag_q <= a_mag_d;
    b_mag_q <= b_mag_d;
    rw_hi_q <= rw_hi_d;
    rw_lo_q <= rw_lo_d;
`ifdef MDU_ACCUM_EN
    acc_op_q <= acc_op_d;
    sub_q    <= sub_d;
    acc_q    <= acc_d;
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.ready = (state_q == S_DONE) && !bus.annul;
  assign bus.hi_o  = hi_q;
  assign bus.lo_o  = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter
// Self-checking bench for mdu_iter (WIDTH=32): directed cases, annul in CALC,
// FIX and DONE, start held high, mid-operation reset, and randomized ops
// compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the op semantics.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ah,
                                        input logic [31:0] al);
    logic [2:0]  o;
    longint      sa, sb, q, r;
    logic [63:0] ps, pu, acc, res;
    o = op;
`ifndef MDU_ACCUM_EN
    if (o[2]) o = {2'b00, o[0]};
`endif
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = 64'(sa * sb);
    pu  = {32'b0, a} * {32'b0, b};
    acc = {ah, al};
    res = '0;
    case (o)
      3'd0: res = ps;
      3'd1: res = pu;
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      3'd4: res = acc + ps;
      3'd5: res = acc + pu;
      3'd6: res = acc - ps;
      default: res = acc - pu;
    endcase
    return res;
  endfunction

  function automatic bit is_dz(input logic [2:0] op, input logic [31:0] b);
    return op[1] && !op[2] && (b == 0);
  endfunction

  // Drive a start pulse; returns #1 after the start edge E0.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ah, input logic [31:0] al);
    @(negedge clk);
    bus.op = op; bus.opa = a; bus.opb = b;
    bus.acc_hi_i = ah; bus.acc_lo_i = al;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Operands only need to be valid at the start edge.
    bus.opa = $urandom; bus.opb = $urandom;
    bus.acc_hi_i = $urandom; bus.acc_lo_i = $urandom;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ah, input logic [31:0] al,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int exp_lat;
    exp_lat = is_dz(op, b) ? 1 : 33;
    lat = -1;
    launch(op, a, b, ah, al);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) check($sformatf("%s.busy_rise", tag), 64'(bus.busy), 64'd1);
      if (bus.ready) begin
        lat = i;
        break;
      end
    end
    check($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s.hi", tag), 64'(bus.hi_o), 64'(exp_hi));
    check($sformatf("%s.lo", tag), 64'(bus.lo_o), 64'(exp_lo));
    @(negedge clk);
    check($sformatf("%s.ready_pulse", tag), 64'(bus.ready), 64'd0);
    check($sformatf("%s.busy_fall", tag), 64'(bus.busy), 64'd0);
    last_hi = exp_hi;
    last_lo = exp_lo;
  endtask

  task automatic model_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ah, input logic [31:0] al);
    logic [63:0] e;
    e = model(op, a, b, ah, al);
    do_op(tag, op, a, b, ah, al, e[63:32], e[31:0]);
  endtask

  // Annul raised right after edge E<at>; the unit must be idle after E<at+1>.
  task automatic run_annul(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int at,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bit saw;
    saw = 1'b0;
    launch(op, a, b, 32'h0, 32'h0);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == at) begin
        bus.annul = 1'b1;
        #1;
      end
      if (bus.ready) saw = 1'b1;
      if (i == at + 1) begin
        check($sformatf("%s.idle", tag), 64'(bus.busy), 64'd0);
        bus.annul = 1'b0;
      end
    end
    check($sformatf("%s.no_ready", tag), 64'(saw), 64'd0);
    check($sformatf("%s.hi", tag), 64'(bus.hi_o), 64'(exp_hi));
    check($sformatf("%s.lo", tag), 64'(bus.lo_o), 64'(exp_lo));
    last_hi = exp_hi;
    last_lo = exp_lo;
  endtask

  int pulses_win;
  int pulses_all;
  bit prev_ready;
  bit saw_ready;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_ah, r_al;
  logic [63:0] e64;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.annul = 1'b0; bus.op = '0;
    bus.opa = '0; bus.opb = '0; bus.acc_hi_i = '0; bus.acc_lo_i = '0;
    repeat (3) @(negedge clk);
    check("reset.busy",  64'(bus.busy),  64'd0);
    check("reset.ready", 64'(bus.ready), 64'd0);
    check("reset.hi",    64'(bus.hi_o),  64'd0);
    check("reset.lo",    64'(bus.lo_o),  64'd0);
    rst = 1'b0;

    // Directed cases with hand-derived results.
    do_op("mult",  3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'h0000_0002, 32'hFFFF_FFFA);
    do_op("div",   3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu0", 3'b011, 32'd7, 32'd0, 0, 0, 32'd7, 32'hFFFF_FFFF);
    do_op("div0s", 3'b010, 32'hFFFF_FFF9, 32'd0, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    do_op("divmin", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h8000_0000);
`ifdef MDU_ACCUM_EN
    do_op("madd", 3'b100, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd5);
    do_op("msub", 3'b110, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    do_op("madd", 3'b100, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFFF, 32'd0, 32'd6);
    do_op("msub", 3'b110, 32'd1, 32'd1, 32'h0, 32'h0, 32'd0, 32'd1);
`endif

    // Annul in CALC, FIX (result must not be written) and DONE (pulse masked).
    run_annul("annul_calc", 3'b011, 32'd1000, 32'd7, 5, last_hi, last_lo);
    run_annul("annul_fix",  3'b001, 32'd9, 32'd9, 32, last_hi, last_lo);
    run_annul("annul_done", 3'b001, 32'd11, 32'd13, 33, 32'd0, 32'd143);

    // start held high: one launch per IDLE visit.
    pulses_win = 0; pulses_all = 0; prev_ready = 1'b0;
    @(negedge clk);
    bus.op = 3'b001; bus.opa = 32'd5; bus.opb = 32'd7;
    bus.start = 1'b1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (j == 109) bus.start = 1'b0;
      if (bus.ready) begin
        pulses_all++;
        if (j < 110) pulses_win++;
      end
      if (bus.ready && prev_ready) check("held.double_pulse", 64'd1, 64'd0);
      prev_ready = bus.ready;
    end
    check("held.pulses_window", 64'(pulses_win), 64'd3);
    check("held.pulses_total",  64'(pulses_all), 64'd4);
    check("held.idle", 64'(bus.busy), 64'd0);
    check("held.lo",   64'(bus.lo_o), 64'd35);

    // Randomized operations against the reference model.
    for (int k = 0; k < 24; k++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      r_ah = $urandom;
      r_al = $urandom;
      if (k % 4 == 1) r_b = r_b & 32'h0000_00FF;
      if (k % 7 == 3) r_b = 32'd0;
      if (k % 5 == 2) r_a = 32'h8000_0000;
      model_op($sformatf("rnd%0d_op%0d", k, r_op), r_op, r_a, r_b, r_ah, r_al);
    end

    // Reset ten cycles into a MULT.
    launch(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.busy",  64'(bus.busy),  64'd0);
    check("rst_mid.ready", 64'(bus.ready), 64'd0);
    check("rst_mid.hi",    64'(bus.hi_o),  64'd0);
    check("rst_mid.lo",    64'(bus.lo_o),  64'd0);
    rst = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) saw_ready = 1'b1;
    end
    check("rst_mid.no_ready", 64'(saw_ready), 64'd0);

    // One more model-checked op after reset.
    e64 = model(3'b010, 32'hFFFF_FF00, 32'd10, 0, 0);
    do_op("post_rst_div", 3'b010, 32'hFFFF_FF00, 32'd10, 0, 0, e64[63:32], e64[31:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
